// File: rtl/div_defs_pkg.sv
// Shared definitions for the sequential divider and the multiplier test top:
// FSM state encodings and default operand widths.
package div_defs;

  localparam int N_DEF = 4;
  localparam int M_DEF = 2;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = IDLE,
    ST_RUN  = RUN,
    ST_DONE = DONE
  } div_state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: compare the shifted partial remainder against
// the divisor and subtract when it fits.
module div_step #(
  parameter int M = 2
) (
  input  logic [M:0]   r_shift,
  input  logic [M-1:0] divisor,
  output logic [M-1:0] r_next,
  output logic         q_bit
);

  // Either branch is below the divisor, so the result always fits in M bits.
  assign q_bit  = (r_shift >= {1'b0, divisor});
  assign r_next = q_bit ? M'(r_shift - {1'b0, divisor}) : r_shift[M-1:0];

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock,
// start/done handshake.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   ST_IDLE | waiting for start; results from the last operation held
//   ST_RUN  | one compare-subtract step per clock, counter counts N..1
//   ST_DONE | done pulse cycle; start accepted here for back-to-back use
module seq_divider
  import div_defs::*;
#(
  parameter int N = N_DEF,
  parameter int M = M_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [M-1:0] divisor,
  output logic         ready,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [M-1:0] remainder,
  output logic         div_by_zero
);

  localparam int CW = $clog2(N + 1);

  div_state_t   state;
  logic [N-1:0] dvd_sh;
  logic [N-1:0] quo_sh;
  logic [M-1:0] dvs;
  // Partial remainder is always below the divisor between steps, so only the
  // shifted value R' needs the extra bit.
  logic [M-1:0] r;
  logic [CW-1:0] cnt;

  logic [M:0]   r_shift;
  logic [M-1:0] r_next;
  logic         q_bit;
  logic [N-1:0] q_next;

  assign r_shift = {r, dvd_sh[N-1]};
  assign q_next  = {quo_sh[N-2:0], q_bit};

  div_step #(.M(M)) u_step (
    .r_shift (r_shift),
    .divisor (dvs),
    .r_next  (r_next),
    .q_bit   (q_bit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      ready       <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      dvd_sh      <= '0;
      quo_sh      <= '0;
      dvs         <= '0;
      r           <= '0;
      cnt         <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            dvd_sh      <= dividend;
            dvs         <= divisor;
            quo_sh      <= '0;
            r           <= '0;
            cnt         <= CW'(N);
            div_by_zero <= 1'b0;
            if (divisor == '0) begin
              state       <= ST_DONE;
              ready       <= 1'b1;
              busy        <= 1'b0;
              done        <= 1'b1;
              quotient    <= '1;
              remainder   <= '0;
              div_by_zero <= 1'b1;
            end else begin
              state <= ST_RUN;
              ready <= 1'b0;
              busy  <= 1'b1;
            end
          end else begin
            state <= ST_IDLE;
            ready <= 1'b1;
            busy  <= 1'b0;
          end
        end
        ST_RUN: begin
          dvd_sh <= {dvd_sh[N-2:0], 1'b0};
          r      <= r_next;
          quo_sh <= q_next;
          cnt    <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state     <= ST_DONE;
            ready     <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b1;
            quotient  <= q_next;
            remainder <= r_next;
          end
        end
        default: begin
          state <= ST_IDLE;
          ready <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider (N=4, M=2) against an arithmetic
// reference built from integer divide and modulo.
module tb_seq_divider;
  localparam int N = 4;
  localparam int M = 2;

  logic         clk;
  logic         rst;
  logic         start;
  logic [N-1:0] dividend;
  logic [M-1:0] divisor;
  logic         ready;
  logic         busy;
  logic         done;
  logic [N-1:0] quotient;
  logic [M-1:0] remainder;
  logic         div_by_zero;

  int vectors;
  int miscompares;

  seq_divider #(.N(N), .M(M)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .ready       (ready),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    @(negedge clk);
    while (ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check("ready_timeout", 32'(ready), 32'd1);
  endtask

  // One division through the handshake, checked against plain arithmetic.
  task automatic do_div(input int a, input int b, input string tag);
    int exp_q, exp_r, exp_z, exp_lat, lat;
    if (b == 0) begin
      exp_q = (1 << N) - 1; exp_r = 0; exp_z = 1; exp_lat = 0;
    end else begin
      exp_q = a / b; exp_r = a % b; exp_z = 0; exp_lat = N;
    end
    wait_ready();
    start = 1'b1; dividend = N'(a); divisor = M'(b);
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    while (done !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_q"}, 32'(quotient), 32'(exp_q));
    check({tag, "_r"}, 32'(remainder), 32'(exp_r));
    check({tag, "_dbz"}, 32'(div_by_zero), 32'(exp_z));
    if (b != 0) begin
      check({tag, "_inv"}, 32'(int'(quotient) * b + int'(remainder)), 32'(a));
      check({tag, "_rlt"}, 32'(int'(remainder) < b), 32'd1);
    end
    @(posedge clk); #1;
    check({tag, "_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    int busy_cnt, done_cnt, a, b;
    vectors = 0; miscompares = 0;
    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_q", 32'(quotient), 32'd0);
    check("rst_r", 32'(remainder), 32'd0);
    check("rst_dbz", 32'(div_by_zero), 32'd0);
    rst = 1'b0;

    do_div(9, 2, "d9_2");
    do_div(15, 3, "d15_3");
    do_div(2, 3, "d2_3");

    for (int x = 0; x < 16; x++)
      for (int y = 1; y < 4; y++)
        do_div(x, y, "sweep");

    do_div(7, 0, "d7_0");
    do_div(6, 2, "d6_2");

    for (int k = 0; k < 30; k++) begin
      a = int'($urandom_range(0, 15));
      b = int'($urandom_range(0, 3));
      do_div(a, b, "rand");
    end

    // Start during RUN must be ignored, and late operand changes too.
    wait_ready();
    start = 1'b1; dividend = 4'd13; divisor = 2'd3;
    @(posedge clk); #1;
    start = 1'b0;
    busy_cnt = 0; done_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      busy_cnt += int'(busy);
      done_cnt += int'(done);
      if (i == 1) begin start = 1'b1; dividend = 4'd8; divisor = 2'd2; end
      if (i == 2) start = 1'b0;
      @(posedge clk); #1;
    end
    check("ign_busy", 32'(busy_cnt), 32'd4);
    check("ign_done", 32'(done_cnt), 32'd1);
    check("ign_q", 32'(quotient), 32'd4);
    check("ign_r", 32'(remainder), 32'd1);

    // Asynchronous reset in the second RUN cycle.
    wait_ready();
    start = 1'b1; dividend = 4'd12; divisor = 2'd1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    check("mid_busy_pre", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check("mid_ready", 32'(ready), 32'd1);
    check("mid_busy", 32'(busy), 32'd0);
    check("mid_q", 32'(quotient), 32'd0);
    check("mid_r", 32'(remainder), 32'd0);
    done_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      done_cnt += int'(done);
    end
    check("mid_nodone", 32'(done_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    do_div(12, 1, "d12_1");

    // Start held high: one result every N+1 cycles, stable in between.
    wait_ready();
    start = 1'b1; dividend = 4'd10; divisor = 2'd3;
    for (int k = 0; k < 16; k++) begin
      @(posedge clk); #1;
      check("b2b_done", 32'(done), 32'((k % (N + 1)) == N));
      if (k >= N) begin
        check("b2b_q", 32'(quotient), 32'd3);
        check("b2b_r", 32'(remainder), 32'd1);
      end
    end
    start = 1'b0;
    repeat (8) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
